// File: rtl/xgmii_rx_link_fault_if.sv
// rtl/xgmii_rx_link_fault_if.sv - 64-bit XGMII word bundle (data, ctrl, block-lock enable)
interface xgmii_rx_link_fault_if;
  logic [63:0] data;
  logic [7:0]  ctrl;
  logic        ena;

  modport master (output data, ctrl, ena);
  modport slave  (input  data, ctrl, ena);
endinterface

// File: rtl/xgmii_rx_link_fault.sv
// rtl/xgmii_rx_link_fault.sv - XGMII RX link-fault monitor with Idle substitution
// Define XGMII_RX_LF_STATS_EN to add lf_event_cnt/rf_event_cnt fault-entry counters.
module xgmii_rx_link_fault #(
  parameter int COL_WINDOW = 128,
  parameter int SEQ_THRESH = 4
) (
  input  logic                          clk_156,
  input  logic                          rst_156_n,
  xgmii_rx_link_fault_if.slave          xgmii_rx_in,
  xgmii_rx_link_fault_if.master         xgmii_rx_out,
  output logic [1:0]                    link_status,
  output logic                          tx_send_rf,
  output logic                          tx_send_idle
`ifdef XGMII_RX_LF_STATS_EN
  ,
  output logic [15:0]                   lf_event_cnt,
  output logic [15:0]                   rf_event_cnt
`endif
);

  localparam int              CW        = $clog2(COL_WINDOW + 1);
  localparam logic [CW-1:0]   WIN       = CW'(COL_WINDOW);
  localparam logic [3:0]      THR       = 4'(SEQ_THRESH);
  localparam logic [63:0]     IDLE_DATA = {8{8'h07}};

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  typedef struct packed {
    state_t          st;
    logic [3:0]      seq;
    logic            last;
    logic [CW-1:0]   col;
    logic [1:0]      ls;
  } fsm_t;

  // Returns 01 for a local sequence, 10 for remote, 00 for any other column.
  function automatic logic [1:0] classify(input logic [31:0] d, input logic [3:0] c,
                                          input logic ena);
    logic [1:0] t;
    t = 2'b00;
    if (!ena) begin
      t = 2'b01;
    end else if (c == 4'b0001 && d[23:0] == 24'h00_009C) begin
      if (d[31:24] == 8'h01)
        t = 2'b01;
      else if (d[31:24] == 8'h02)
        t = 2'b10;
    end
    return t;
  endfunction

  function automatic fsm_t step(input fsm_t s, input logic [1:0] typ);
    fsm_t n;
    logic rem;
    n   = s;
    rem = typ[1];
    if (typ != 2'b00) begin
      case (s.st)
        ST_INIT: begin
          n.st   = ST_COUNT;
          n.seq  = 4'd1;
          n.last = rem;
          n.col  = '0;
        end
        ST_COUNT: begin
          n.col = '0;
          if (rem == s.last) begin
            n.seq = s.seq + 4'd1;
            if (n.seq == THR) begin
              n.st = ST_FAULT;
              n.ls = typ;
            end
          end else begin
            n.seq  = 4'd1;
            n.last = rem;
          end
        end
        ST_FAULT: begin
          n.col = '0;
          // A type change restarts counting but keeps reporting the old fault.
          if (rem != s.last) begin
            n.st   = ST_COUNT;
            n.seq  = 4'd1;
            n.last = rem;
          end
        end
        default: begin
          n.st  = ST_INIT;
          n.seq = 4'd0;
          n.ls  = 2'b00;
        end
      endcase
    end else if (s.st != ST_INIT) begin
      if (s.col != WIN)
        n.col = s.col + CW'(1);
      if (n.col == WIN) begin
        n.st  = ST_INIT;
        n.seq = 4'd0;
        n.ls  = 2'b00;
      end
    end
    return n;
  endfunction

  state_t          state;
  logic [3:0]      seq_cnt;
  logic            last_type;
  logic [CW-1:0]   col_cnt;

  fsm_t            cur;
  fsm_t            mid;
  fsm_t            nxt;
  logic [1:0]      type0;
  logic [1:0]      type1;

  always_comb begin
    cur   = '{st: state, seq: seq_cnt, last: last_type, col: col_cnt, ls: link_status};
    type0 = classify(xgmii_rx_in.data[31:0],  xgmii_rx_in.ctrl[3:0], xgmii_rx_in.ena);
    type1 = classify(xgmii_rx_in.data[63:32], xgmii_rx_in.ctrl[7:4], xgmii_rx_in.ena);
    mid   = step(cur, type0);
    nxt   = step(mid, type1);
  end

  always_ff @(posedge clk_156 or negedge rst_156_n) begin
    if (!rst_156_n) begin
      state             <= ST_INIT;
      seq_cnt           <= 4'd0;
      last_type         <= 1'b0;
      col_cnt           <= '0;
      link_status       <= 2'b00;
      tx_send_rf        <= 1'b0;
      tx_send_idle      <= 1'b0;
      xgmii_rx_out.data <= IDLE_DATA;
      xgmii_rx_out.ctrl <= 8'hFF;
      xgmii_rx_out.ena  <= 1'b0;
    end else begin
      state        <= nxt.st;
      seq_cnt      <= nxt.seq;
      last_type    <= nxt.last;
      col_cnt      <= nxt.col;
      link_status  <= nxt.ls;
      tx_send_rf   <= (nxt.ls == 2'b01);
      tx_send_idle <= (nxt.ls == 2'b10);
      if (nxt.ls != 2'b00) begin
        xgmii_rx_out.data <= IDLE_DATA;
        xgmii_rx_out.ctrl <= 8'hFF;
      end else begin
        xgmii_rx_out.data <= xgmii_rx_in.data;
        xgmii_rx_out.ctrl <= xgmii_rx_in.ctrl;
      end
      xgmii_rx_out.ena <= xgmii_rx_in.ena;
    end
  end

`ifdef XGMII_RX_LF_STATS_EN
  logic        ent0;
  logic        ent1;
  logic [1:0]  lf_inc;
  logic [1:0]  rf_inc;
  logic [16:0] lf_sum;
  logic [16:0] rf_sum;

  // A FAULT entry is a step that moves the FSM into FAULT from elsewhere.
  always_comb begin
    ent0   = (cur.st != ST_FAULT) && (mid.st == ST_FAULT);
    ent1   = (mid.st != ST_FAULT) && (nxt.st == ST_FAULT);
    lf_inc = 2'({1'b0, ent0 && mid.ls == 2'b01}) + 2'({1'b0, ent1 && nxt.ls == 2'b01});
    rf_inc = 2'({1'b0, ent0 && mid.ls == 2'b10}) + 2'({1'b0, ent1 && nxt.ls == 2'b10});
    lf_sum = 17'(lf_event_cnt) + 17'(lf_inc);
    rf_sum = 17'(rf_event_cnt) + 17'(rf_inc);
  end

  always_ff @(posedge clk_156 or negedge rst_156_n) begin
    if (!rst_156_n) begin
      lf_event_cnt <= 16'd0;
      rf_event_cnt <= 16'd0;
    end else begin
      lf_event_cnt <= lf_sum[16] ? 16'hFFFF : lf_sum[15:0];
      rf_event_cnt <= rf_sum[16] ? 16'hFFFF : rf_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_xgmii_rx_link_fault.sv
// tb/tb_xgmii_rx_link_fault.sv - self-checking bench for xgmii_rx_link_fault
`timescale 1ns/1ps
module tb_xgmii_rx_link_fault;

  localparam int          WINDOW = 128;
  localparam int          THRESH = 4;
  localparam logic [63:0] IDLE   = 64'h0707_0707_0707_0707;
  localparam logic [35:0] C_LF   = {4'b0001, 32'h0100_009C};
  localparam logic [35:0] C_RF   = {4'b0001, 32'h0200_009C};
  localparam logic [35:0] C_ID   = {4'hF,    32'h0707_0707};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] link_status;
  logic       tx_send_rf;
  logic       tx_send_idle;
`ifdef XGMII_RX_LF_STATS_EN
  logic [15:0] lf_event_cnt;
  logic [15:0] rf_event_cnt;
`endif

  xgmii_rx_link_fault_if rx_in ();
  xgmii_rx_link_fault_if rx_out ();

  xgmii_rx_link_fault #(.COL_WINDOW(WINDOW), .SEQ_THRESH(THRESH)) dut (
    .clk_156      (clk),
    .rst_156_n    (rst_n),
    .xgmii_rx_in  (rx_in),
    .xgmii_rx_out (rx_out),
    .link_status  (link_status),
    .tx_send_rf   (tx_send_rf),
    .tx_send_idle (tx_send_idle)
`ifdef XGMII_RX_LF_STATS_EN
    ,
    .lf_event_cnt (lf_event_cnt),
    .rf_event_cnt (rf_event_cnt)
`endif
  );

  always #3.2 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0 idle, 1 counting a run, 2 fault reported.
  int m_mode, m_run, m_rtype, m_quiet, m_ls, m_lf, m_rf;
  logic [63:0] exp_data;
  logic [7:0]  exp_ctrl;
  logic        exp_ena;
  logic [75:0] exp_vec;
  logic [75:0] act_vec;

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_rtype = 0; m_quiet = 0; m_ls = 0; m_lf = 0; m_rf = 0;
  endtask

  function automatic int col_type(input logic [31:0] d, input logic [3:0] c, input logic e);
    if (!e) return 1;
    if (c == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
      if (d[31:24] == 8'h01) return 1;
      if (d[31:24] == 8'h02) return 2;
    end
    return 0;
  endfunction

  task automatic model_col(input int typ);
    if (typ != 0) begin
      m_quiet = 0;
      if (m_mode == 0 || typ != m_rtype) begin
        m_mode = 1; m_run = 1; m_rtype = typ;
      end else if (m_mode == 1) begin
        m_run = m_run + 1;
        if (m_run >= THRESH) begin
          m_mode = 2;
          m_ls   = typ;
          if (typ == 1 && m_lf < 65535) m_lf = m_lf + 1;
          if (typ == 2 && m_rf < 65535) m_rf = m_rf + 1;
        end
      end
    end else if (m_mode != 0) begin
      m_quiet = m_quiet + 1;
      if (m_quiet >= WINDOW) begin
        m_mode = 0; m_run = 0; m_ls = 0;
      end
    end
  endtask

  function automatic logic [35:0] mk_col(input int kind);
    logic [31:0] r;
    r = $urandom();
    case (kind)
      0:       return C_LF;
      1:       return C_RF;
      2:       return C_ID;
      3:       return {4'($urandom_range(0, 15)), r};
      default: return {4'b0001, 8'($urandom_range(3, 255)), 24'h00_009C};
    endcase
  endfunction

  // Drives one word on the falling edge and samples just after the next rising edge.
  task automatic apply(input logic [35:0] c0, input logic [35:0] c1, input logic e);
    @(negedge clk);
    rx_in.data = {c1[31:0], c0[31:0]};
    rx_in.ctrl = {c1[35:32], c0[35:32]};
    rx_in.ena  = e;
    model_col(col_type(c0[31:0], c0[35:32], e));
    model_col(col_type(c1[31:0], c1[35:32], e));
    exp_data = (m_ls != 0) ? IDLE  : rx_in.data;
    exp_ctrl = (m_ls != 0) ? 8'hFF : rx_in.ctrl;
    exp_ena  = e;
    exp_vec  = {2'(m_ls), m_ls == 1, m_ls == 2, exp_data, exp_ctrl, exp_ena};
    @(posedge clk);
    #1;
    act_vec  = {link_status, tx_send_rf, tx_send_idle, rx_out.data, rx_out.ctrl, rx_out.ena};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_in.data = IDLE; rx_in.ctrl = 8'hFF; rx_in.ena = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({link_status, tx_send_rf, tx_send_idle} !== 4'b0000)
      $display("FAIL reset_status actual=%b required=0000", {link_status, tx_send_rf, tx_send_idle});
    else n_pass++;
    n_checks++;
    if ({rx_out.data, rx_out.ctrl, rx_out.ena} !== {IDLE, 8'hFF, 1'b0})
      $display("FAIL reset_out actual=%h required=%h", {rx_out.data, rx_out.ctrl, rx_out.ena},
               {IDLE, 8'hFF, 1'b0});
    else n_pass++;
`ifdef XGMII_RX_LF_STATS_EN
    n_checks++;
    if ({lf_event_cnt, rf_event_cnt} !== 32'h0)
      $display("FAIL reset_stats actual=%h required=0", {lf_event_cnt, rf_event_cnt});
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_pass();
    for (int i = 0; i < 8; i++) begin
      apply(mk_col(2 + (i % 2)), mk_col(3), 1'b1);
      n_checks++;
      if (act_vec !== exp_vec || link_status !== 2'b00)
        $display("FAIL idle_pass[%0d] actual=%h required=%h", i, act_vec, exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_local_fault();
    apply(C_LF, C_LF, 1'b1);
    n_checks++;
    if (link_status !== 2'b00 || rx_out.data !== {C_LF[31:0], C_LF[31:0]})
      $display("FAIL lf_word1 actual=%b/%h required=00/%h", link_status, rx_out.data,
               {C_LF[31:0], C_LF[31:0]});
    else n_pass++;
    apply(C_LF, C_LF, 1'b1);
    n_checks++;
    if ({link_status, tx_send_rf, tx_send_idle} !== 4'b0110)
      $display("FAIL lf_word2_status actual=%b required=0110", {link_status, tx_send_rf, tx_send_idle});
    else n_pass++;
    n_checks++;
    if ({rx_out.data, rx_out.ctrl} !== {IDLE, 8'hFF})
      $display("FAIL lf_word2_idle actual=%h required=%h", {rx_out.data, rx_out.ctrl}, {IDLE, 8'hFF});
    else n_pass++;
  endtask

  task automatic test_window();
    for (int i = 0; i < 63; i++) begin
      apply(C_ID, C_ID, 1'b1);
      n_checks++;
      if (link_status !== 2'b01 || rx_out.ctrl !== 8'hFF)
        $display("FAIL window_hold[%0d] actual=%b required=01", i, link_status);
      else n_pass++;
    end
    apply(mk_col(3), mk_col(4), 1'b1);
    n_checks++;
    if (link_status !== 2'b00 || tx_send_rf !== 1'b0)
      $display("FAIL window_clear actual=%b required=00", link_status);
    else n_pass++;
    n_checks++;
    if ({rx_out.data, rx_out.ctrl} !== {rx_in.data, rx_in.ctrl})
      $display("FAIL window_pass actual=%h required=%h", {rx_out.data, rx_out.ctrl},
               {rx_in.data, rx_in.ctrl});
    else n_pass++;
  endtask

  task automatic test_remote();
    apply(C_LF, C_LF, 1'b1);
    apply(C_LF, C_RF, 1'b1);
    apply(C_RF, C_RF, 1'b1);
    n_checks++;
    if (link_status !== 2'b00)
      $display("FAIL rf_before actual=%b required=00", link_status);
    else n_pass++;
    apply(C_RF, C_ID, 1'b1);
    n_checks++;
    if ({link_status, tx_send_rf, tx_send_idle} !== 4'b1001)
      $display("FAIL rf_status actual=%b required=1001", {link_status, tx_send_rf, tx_send_idle});
    else n_pass++;
    n_checks++;
    if (act_vec !== exp_vec)
      $display("FAIL rf_model actual=%h required=%h", act_vec, exp_vec);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({link_status, tx_send_rf, tx_send_idle, rx_out.data, rx_out.ctrl, rx_out.ena} !==
        {4'b0000, IDLE, 8'hFF, 1'b0})
      $display("FAIL reset_mid actual=%b/%h required=0000/%h", {link_status, tx_send_rf, tx_send_idle},
               rx_out.data, IDLE);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(C_RF, C_ID, 1'b1);
    n_checks++;
    if (link_status !== 2'b00 || act_vec !== exp_vec)
      $display("FAIL reset_restart actual=%h required=%h", act_vec, exp_vec);
    else n_pass++;
  endtask

  task automatic test_ena_low();
    apply(C_ID, C_ID, 1'b0);
    n_checks++;
    if (link_status !== 2'b00 || rx_out.ena !== 1'b0 || rx_out.data !== IDLE)
      $display("FAIL ena_word1 actual=%b/%b required=00/0", link_status, rx_out.ena);
    else n_pass++;
    apply(C_ID, C_ID, 1'b0);
    n_checks++;
    if ({link_status, tx_send_rf} !== 3'b011)
      $display("FAIL ena_word2 actual=%b required=011", {link_status, tx_send_rf});
    else n_pass++;
`ifdef XGMII_RX_LF_STATS_EN
    n_checks++;
    if (lf_event_cnt !== 16'd1 || rf_event_cnt !== 16'd0)
      $display("FAIL ena_stats1 actual=%0d/%0d required=1/0", lf_event_cnt, rf_event_cnt);
    else n_pass++;
`endif
    for (int i = 0; i < 64; i++) apply(C_ID, C_ID, 1'b1);
    n_checks++;
    if (link_status !== 2'b00)
      $display("FAIL ena_clear actual=%b required=00", link_status);
    else n_pass++;
    apply(C_ID, C_ID, 1'b0);
    apply(C_ID, C_ID, 1'b0);
    n_checks++;
    if (link_status !== 2'b01)
      $display("FAIL ena_again actual=%b required=01", link_status);
    else n_pass++;
`ifdef XGMII_RX_LF_STATS_EN
    n_checks++;
    if (lf_event_cnt !== 16'd2)
      $display("FAIL ena_stats2 actual=%0d required=2", lf_event_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    int k0, k1;
    logic e;
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 90; i++) begin
        if (i < 20) begin
          k0 = $urandom_range(0, 4);
          k1 = $urandom_range(0, 4);
          e  = ($urandom_range(0, 9) != 0);
        end else begin
          k0 = 2 + $urandom_range(0, 2);
          k1 = 2 + $urandom_range(0, 2);
          e  = 1'b1;
        end
        apply(mk_col(k0), mk_col(k1), e);
        n_checks++;
        if (act_vec !== exp_vec)
          $display("FAIL random[%0d.%0d] actual=%h required=%h", blk, i, act_vec, exp_vec);
        else n_pass++;
`ifdef XGMII_RX_LF_STATS_EN
        n_checks++;
        if (lf_event_cnt !== 16'(m_lf) || rf_event_cnt !== 16'(m_rf))
          $display("FAIL random_stats[%0d.%0d] actual=%0d/%0d required=%0d/%0d", blk, i,
                   lf_event_cnt, rf_event_cnt, m_lf, m_rf);
        else n_pass++;
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_pass();
    test_local_fault();
    test_window();
    test_remote();
    test_reset_mid();
    test_ena_low();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
